// File: rtl/sm_arith_pkg.sv
// Shared types, widths and helpers for the sign-magnitude arithmetic unit.
// Saturation in the adder lanes is selected with the SM_SAT_EN macro.
package sm_arith_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int WIDE_DEF       = 2 * DATA_WIDTH_DEF;

  typedef logic [WIDE_DEF-1:0] sm_word_t;

  localparam sm_word_t SM_ZERO = '0;

  function automatic logic sm_sign(input sm_word_t v);
    return v[WIDE_DEF-1];
  endfunction

  function automatic logic [WIDE_DEF-2:0] sm_mag(input sm_word_t v);
    return v[WIDE_DEF-2:0];
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// Combinational sign-magnitude add/subtract of width W.
// SM_SAT_EN defined: same-sign overflow saturates, otherwise it wraps.
module sm_add_core
  import sm_arith_pkg::*;
#(
  parameter int W = WIDE_DEF
) (
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam int M = W - 1;

  logic         sa;
  logic         sb;
  logic [M-1:0] ma;
  logic [M-1:0] mb;
  logic [M:0]   sum;
  logic [M-1:0] mag;
  logic         sgn;

  // Magnitude compare and add/subtract, then zero-sign fix.
  always_comb begin
    ma  = a[M-1:0];
    mb  = b[M-1:0];
    sa  = a[W-1];
    sb  = b[W-1] ^ sub;
    sum = {1'b0, ma} + {1'b0, mb};
    mag = '0;
    sgn = 1'b0;
    if (sa == sb) begin
      sgn = sa;
`ifdef SM_SAT_EN
      mag = sum[M] ? {M{1'b1}} : sum[M-1:0];
`else
      mag = sum[M-1:0];
`endif
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    y = {sgn & (|mag), mag};
  end

endmodule

// File: rtl/sm_arith_unit.sv
// Sign-magnitude multiplier, registered adder and combinational adder.
// SM_SAT_EN selects saturating overflow in both adder lanes.
module sm_arith_unit
  import sm_arith_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   mul_a,
  input  logic [DATA_WIDTH-1:0]   mul_b,
  output logic [2*DATA_WIDTH-1:0] mul_p,
  input  logic                    add_sub,
  input  logic [2*DATA_WIDTH-1:0] add_a,
  input  logic [2*DATA_WIDTH-1:0] add_b,
  output logic [2*DATA_WIDTH-1:0] add_q,
  input  logic                    cadd_sub,
  input  logic [2*DATA_WIDTH-1:0] cadd_a,
  input  logic [2*DATA_WIDTH-1:0] cadd_b,
  output logic [2*DATA_WIDTH-1:0] cadd_y
);

  localparam int DW = DATA_WIDTH;
  localparam int W  = 2 * DATA_WIDTH;

  logic [2*DW-3:0] prod;
  logic            psign;
  logic [W-1:0]    mul_p_d;
  logic [W-1:0]    mul_p_q;
  logic [W-1:0]    add_q_d;
  logic [W-1:0]    add_q_q;

  // Magnitude product, sign XOR, and +0 for a zero product.
  always_comb begin
    prod    = mul_a[DW-2:0] * mul_b[DW-2:0];
    psign   = (mul_a[DW-1] ^ mul_b[DW-1]) & (|prod);
    mul_p_d = {psign, 1'b0, prod};
  end

  sm_add_core #(.W(W)) u_add_reg (
    .sub (add_sub),
    .a   (add_a),
    .b   (add_b),
    .y   (add_q_d)
  );

  sm_add_core #(.W(W)) u_add_comb (
    .sub (cadd_sub),
    .a   (cadd_a),
    .b   (cadd_b),
    .y   (cadd_y)
  );

  // Both registered lanes load every edge; reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_p_q <= '0;
      add_q_q <= '0;
    end else begin
      mul_p_q <= mul_p_d;
      add_q_q <= add_q_d;
    end
  end

  assign mul_p = mul_p_q;
  assign add_q = add_q_q;

endmodule

// File: tb/tb_sm_arith_unit.sv
// Self-checking bench for sm_arith_unit with a signed-integer model.
// Honours SM_SAT_EN the same way as the design.
module tb_sm_arith_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p;
  logic        add_sub;
  logic [31:0] add_a, add_b, add_q;
  logic        cadd_sub;
  logic [31:0] cadd_a, cadd_b, cadd_y;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] em, ea;

  sm_arith_unit dut (
    .clk      (clk),
    .rst      (rst),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_p    (mul_p),
    .add_sub  (add_sub),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_q    (add_q),
    .cadd_sub (cadd_sub),
    .cadd_a   (cadd_a),
    .cadd_b   (cadd_b),
    .cadd_y   (cadd_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Real signed arithmetic, then re-encoded as sign-magnitude.
  function automatic logic [31:0] m_add(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic sub);
    longint va, vb, r, mag;
    logic [63:0] mb;
    va = a[30:0];
    vb = b[30:0];
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    if (sub) vb = -vb;
    r   = va + vb;
    mag = (r < 0) ? -r : r;
    if (mag > 64'h7FFF_FFFF) begin
`ifdef SM_SAT_EN
      mag = 64'h7FFF_FFFF;
`else
      mag = mag % 64'h8000_0000;
`endif
    end
    mb = mag;
    return {(r < 0) && (mag != 0), mb[30:0]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [15:0] a,
                                        input logic [15:0] b);
    longint pa, pb, p;
    logic [63:0] pm;
    pa = a[14:0];
    pb = b[14:0];
    p  = pa * pb;
    pm = p;
    return {(a[15] ^ b[15]) && (p != 0), pm[30:0]};
  endfunction

  // Expected registered outputs: last sampled inputs, or zero in reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      em <= '0;
      ea <= '0;
    end else begin
      em <= m_mul(mul_a, mul_b);
      ea <= m_add(add_a, add_b, add_sub);
    end
  end

  // Every cycle, mid-period, all three outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mul_p", mul_p, em);
      chk("add_q", add_q, ea);
      chk("cadd_y", cadd_y, m_add(cadd_a, cadd_b, cadd_sub));
    end
  end

  function automatic logic [31:0] rnd_word();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      0: v[30:0] = {31{1'b1}} - 31'($urandom_range(0, 3));
      1: v[30:0] = 31'($urandom_range(0, 3));
      default: ;
    endcase
    return v;
  endfunction

  task automatic rnd_inputs();
    mul_a    = 16'($urandom);
    mul_b    = 16'($urandom);
    add_sub  = 1'($urandom);
    add_a    = rnd_word();
    add_b    = ($urandom_range(0, 5) == 0) ?
               {1'($urandom), add_a[30:0]} : rnd_word();
    cadd_sub = 1'($urandom);
    cadd_a   = rnd_word();
    cadd_b   = ($urandom_range(0, 5) == 0) ?
               {1'($urandom), cadd_a[30:0]} : rnd_word();
  endtask

  task automatic next_slot();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] hold_m, hold_a;

  initial begin
    rst = 1'b1;
    mul_a = '0; mul_b = '0;
    add_sub = 1'b0; add_a = '0; add_b = '0;
    cadd_sub = 1'b0; cadd_a = '0; cadd_b = '0;
    #1;
    chk("reset mul_p", mul_p, 32'h0);
    chk("reset add_q", add_q, 32'h0);
    next_slot();
    rst = 1'b0;
    chk_en = 1'b1;

    mul_a = 16'h8003; mul_b = 16'h0005;
    add_a = 32'h0000_000A; add_b = 32'h8000_0003; add_sub = 1'b0;
    cadd_a = 32'h0000_0005; cadd_b = 32'h0000_0007; cadd_sub = 1'b1;
    #1;
    chk("cadd 5-7", cadd_y, 32'h8000_0002);
    @(posedge clk); #1;
    chk("mul -3*5", mul_p, 32'h8000_000F);
    chk("add 10+-3", add_q, 32'h0000_0007);
    #1;

    mul_a = 16'h8000; mul_b = 16'h8007;
    add_a = 32'h0000_0005; add_b = 32'h0000_0007; add_sub = 1'b1;
    cadd_a = 32'h8000_1234; cadd_b = 32'h0000_1234; cadd_sub = 1'b0;
    #1;
    chk("cadd cancel", cadd_y, 32'h0000_0000);
    @(posedge clk); #1;
    chk("mul -0", mul_p, 32'h0000_0000);
    chk("add 5-7", add_q, 32'h8000_0002);
    #1;

    add_a = 32'h7FFF_FFFF; add_b = 32'h0000_0001; add_sub = 1'b0;
    @(posedge clk); #1;
`ifdef SM_SAT_EN
    chk("add ovf pos", add_q, 32'h7FFF_FFFF);
`else
    chk("add ovf pos", add_q, 32'h0000_0000);
`endif
    #1;

    add_a = 32'hFFFF_FFFF; add_b = 32'h8000_0001;
    @(posedge clk); #1;
`ifdef SM_SAT_EN
    chk("add ovf neg", add_q, 32'hFFFF_FFFF);
`else
    chk("add ovf neg", add_q, 32'h0000_0000);
`endif
    #1;

    for (int i = 0; i < 300; i++) begin
      rnd_inputs();
      next_slot();
    end

    rst = 1'b1;
    #1;
    chk("async rst mul_p", mul_p, 32'h0);
    chk("async rst add_q", add_q, 32'h0);
    next_slot();
    chk("held rst mul_p", mul_p, 32'h0);
    chk("held rst add_q", add_q, 32'h0);
    rnd_inputs();
    hold_m = m_mul(mul_a, mul_b);
    hold_a = m_add(add_a, add_b, add_sub);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post rst mul_p", mul_p, hold_m);
    chk("post rst add_q", add_q, hold_a);
    #1;

    for (int i = 0; i < 200; i++) begin
      rnd_inputs();
      next_slot();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_arith_unit.md
# sm_arith_unit

Sign-magnitude arithmetic primitives for the fully-connected layers of the accelerator. The block bundles three lanes: a registered DATA_WIDTH×DATA_WIDTH multiplier (multiply_unit), a registered 2·DATA_WIDTH adder/subtractor used at every adder-tree level (adder_fc), and a combinational 2·DATA_WIDTH adder/subtractor used for bias addition (adder). All operands and results use sign-magnitude format: the MSB is the sign (1 = negative) and the remaining bits are the magnitude.

## Interface
- DATA_WIDTH, 16, operand width; products and sums are 2·DATA_WIDTH wide.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mul_a  in  DATA_WIDTH  multiplicand (sign-magnitude).
- mul_b  in  DATA_WIDTH  multiplier (sign-magnitude).
- mul_p  out  2·DATA_WIDTH  registered product.
- add_sub  in  1  registered-lane control: 0 = a+b, 1 = a−b.
- add_a, add_b  in  2·DATA_WIDTH  registered-lane operands.
- add_q  out  2·DATA_WIDTH  registered sum.
- cadd_sub  in  1  combinational-lane control: 0 = a+b, 1 = a−b.
- cadd_a, cadd_b  in  2·DATA_WIDTH  combinational-lane operands.
- cadd_y  out  2·DATA_WIDTH  combinational sum.

## Operation
- Let W = 2·DATA_WIDTH and M = W−1 (magnitude width of wide values).
- Multiply:
  - Magnitude = mul_a[DW-2:0] × mul_b[DW-2:0], zero-extended to M bits. This fits without overflow; the top magnitude bit is always 0.
  - Sign = mul_a[DW-1] XOR mul_b[DW-1].
  - Sign is forced to 0 when the magnitude is 0.
- Add/subtract (both lanes, identical arithmetic):
  - Effective b sign = b[W-1] XOR sub.
  - Signs equal: magnitude = |a| + |b| on M bits; sign = the common sign.
  - Signs differ: the larger magnitude minus the smaller; sign = sign of the operand with the larger magnitude.
  - Equal magnitudes with differing signs give +0 (all bits zero).
  - Any result with zero magnitude has sign 0. Inputs of −0 are treated as +0.
- Overflow (same-sign carry out of M bits):
  - Default: the carry is discarded and the magnitude wraps mod 2^M. Sign is kept, except that a zero magnitude gives sign 0.
  - See Configuration for saturation.
- No enable inputs. The registered lanes load on every clock edge.

## Timing
- mul_p: latency 1 cycle. Operands sampled at edge N appear on mul_p after edge N.
- add_q: latency 1 cycle, throughput 1 per cycle.
- cadd_y: zero latency, purely combinational from cadd_* inputs.
- Reset values: mul_p = 0, add_q = 0. cadd_y has no state.
- rst asserted at any time, including mid-stream, clears mul_p and add_q immediately without waiting for clk.
- The first edge after rst deasserts captures the then-current inputs normally.
- Back-to-back operands each cycle produce back-to-back results with no bubbles.

## Configuration
- SM_SAT_EN defined:
  - On same-sign magnitude overflow in either adder lane, the magnitude saturates to all ones (2^M−1) and the sign is kept.
  - Example for W = 32: the result is 0x7FFFFFFF or 0xFFFFFFFF.
- SM_SAT_EN undefined: wrap behaviour as in Operation.
- The multiplier is unaffected by SM_SAT_EN because it cannot overflow.

## Structure
- Shared package sm_arith_pkg:
  - default DATA_WIDTH;
  - functions sm_sign and sm_mag;
  - the canonical zero constant.
- One sub-module, sm_add_core: a combinational sign-magnitude add/subtract parameterised on W, including the SM_SAT_EN logic.
  - The combinational lane instantiates it directly.
  - The registered lane is sm_add_core followed by the output register.
- The multiplier lane is inline: product, sign XOR, zero-sign fix, then the register.

## Test plan
- Multiply, DW = 16: mul_a = 0x8003 (−3), mul_b = 0x0005 → mul_p = 0x8000000F one cycle later. mul_a = 0x8000 (−0), mul_b = 0x8007 → 0x00000000.
- Registered add: add_a = 0x0000000A, add_b = 0x80000003, add_sub = 0 → add_q = 0x00000007 next cycle.
- Subtract: add_a = 0x00000005, add_b = 0x00000007, add_sub = 1 → add_q = 0x80000002. Same operands on cadd_* → cadd_y = 0x80000002 in the same cycle.
- Cancellation: cadd_a = 0x80001234, cadd_b = 0x00001234, cadd_sub = 0 → cadd_y = 0x00000000 (sign 0).
- Overflow: add_a = 0x7FFFFFFF, add_b = 0x00000001 → add_q = 0x00000000 without SM_SAT_EN, 0x7FFFFFFF with it. For 0xFFFFFFFF + 0x80000001 with SM_SAT_EN → 0xFFFFFFFF.
- Async reset: stream operands each cycle, then assert rst between edges → mul_p and add_q read 0 before the next clk edge. After rst deasserts, the first result appears one edge later.
